riscv_run_monitor: RTL and testbench
====================================

Name: riscv_run_monitor

Overview:
- Synthesizable run controller and monitor for the RV32I core.
- Sequences the core reset for a programmable number of cycles, then counts cycles and retired instructions.
- Ends the run on a tohost store, a cycle timeout, or a retire-stall hang, and latches a pass/fail verdict.
- Sits beside RISCV_TopModule in the top-level harness and replaces fixed-delay reset/finish sequencing with parametrised, observable run control.

Parameters:
- RST_CYCLES, 4: number of cycles core_rst is held high after start.
- TIMEOUT, 100: maximum RUN cycles before the timeout verdict; must be at least 2.
- STALL_LIMIT, 16: consecutive RUN cycles without a retire that flag a hang; must be at least 2.
- TOHOST_ADDR, 32'h0000_0FF0: store address that signals the end of a test.
- CNT_W, 32: width of cycle_count and retire_count.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- mem_we, input, 1: core data-store strobe.
- mem_addr, input, 32: core data-store address.
- mem_wdata, input, 32: core data-store data.
- retire, input, 1: one instruction retired this cycle.
- core_rst, output, 1: active-high reset driven to the core.
- running, output, 1: high while in RUN.
- done, output, 1: run finished, verdict valid.
- pass, output, 1: tohost value was exactly 1.
- fail_code, output, 31: mem_wdata[31:1] of the terminating tohost store; 0 on timeout or hang.
- timed_out, output, 1: run ended by TIMEOUT.
- hang, output, 1: run ended by STALL_LIMIT.
- cycle_count, output, CNT_W: RUN cycles elapsed.
- retire_count, output, CNT_W: instructions retired during RUN.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE. core_rst=1, and every other output is 0.
- FSM states: IDLE, RST_HOLD, RUN, DONE.
- IDLE: core_rst=1. On start, clear all counters and the verdict, then go to RST_HOLD.
- RST_HOLD: core_rst=1. The hold counter counts 0..RST_CYCLES-1, so core_rst stays high for exactly RST_CYCLES cycles after the start edge, then the FSM enters RUN.
- RUN: core_rst=0 and running=1.
  - cycle_count increments every RUN cycle and saturates at its maximum value.
  - retire_count increments on each retire and saturates.
  - The stall counter clears on retire and increments otherwise.
- Termination is evaluated every RUN cycle, first match wins:
  - (1) tohost: mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1. Latch pass = (mem_wdata==1) and fail_code = mem_wdata[31:1].
  - (2) timeout: cycle_count==TIMEOUT-1. Set timed_out=1.
  - (3) hang: the stall counter reaches STALL_LIMIT-1 and retire=0. Set hang=1.
- Any terminating cycle moves the FSM to DONE. On the terminating cycle the counters still update; they freeze afterwards.
- Tohost stores with mem_wdata[0]=0, or to any other address, are ignored.
- DONE: done=1, core_rst=1 (core held), verdict and counters held. start restarts the sequence exactly as from IDLE.
- start in RST_HOLD or RUN is ignored.
- Asserting reset mid-run aborts immediately: state returns to IDLE, the verdict and counters clear, and core_rst=1.
- Outputs are registered. done, the verdict and running change on the clock edge after the terminating cycle.
- Exactly one of pass, fail (fail_code≠0 or a tohost value ≠1), timed_out, or hang is meaningful when done=1.

Decomposition:
- Shared package riscv_run_pkg holds:
  - the state encoding (IDLE=2'd0, RST_HOLD=2'd1, RUN=2'd2, DONE=2'd3);
  - the TOHOST_ADDR default;
  - the verdict enum (V_NONE, V_PASS, V_FAIL, V_TIMEOUT, V_HANG).
- One sub-module is natural: sat_counter (parametrised width, clear, enable, saturate). It is instantiated for cycle_count, retire_count and the stall counter.

Test Plan:
- Reset defaults: reset=0 for 3 cycles → core_rst=1 and all other outputs 0. Release reset with no start → the FSM stays in IDLE.
- Reset hold length: start pulse with RST_CYCLES=4 → core_rst high for exactly 4 cycles after start, then running=1 on the next edge.
- Pass: in RUN, retire every cycle; on cycle 20, store mem_addr=0x0FF0, mem_wdata=1.
  - Expect done=1, pass=1, fail_code=0, cycle_count=21, retire_count=21.
- Fail, and same-cycle priority: TIMEOUT=100 and STALL_LIMIT=16 with retire every cycle. Store 0x0FF0 with mem_wdata=0x0000_0007 on cycle 99, the same cycle the timeout would fire.
  - Expect done=1, pass=0, fail_code=3, timed_out=0.
- Timeout and hang:
  - Retire every cycle with no tohost → timed_out=1 with cycle_count=100.
  - Separately, hold retire=0 from RUN entry → hang=1 with cycle_count=16 and retire_count=0.
- Abort and restart:
  - Drop reset on RUN cycle 10 → immediate IDLE with counters 0.
  - Later, a start pulse from DONE → counters clear, core_rst high for 4 cycles, and a new run proceeds normally.

Source files
------------

// File: rtl/riscv_run_pkg.sv
// Shared types for the RV32I run monitor: FSM encoding, verdict kinds and
// the default tohost mailbox address.
package riscv_run_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RST_HOLD = 2'd1,
      RUN      = 2'd2,
      DONE     = 2'd3
   } run_state_e;

   typedef enum logic [2:0] {
      V_NONE,
      V_PASS,
      V_FAIL,
      V_TIMEOUT,
      V_HANG
   } verdict_e;

   localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FF0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (clear beats enable) that sticks at its
// all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller for the RV32I core: holds core reset, runs, counts cycles and
// retires, and ends the run on tohost, timeout or retire-stall with a verdict.
module riscv_run_monitor
   import riscv_run_pkg::*;
#(
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned TIMEOUT     = 100,
   parameter int unsigned STALL_LIMIT = 16,
   parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mem_we,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic             retire,
   output logic             core_rst,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic [30:0]      fail_code,
   output logic             timed_out,
   output logic             hang,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
);

   localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);

   run_state_e         state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               pass_q, pass_d;
   logic [30:0]        fail_code_q, fail_code_d;
   logic               timed_out_q, timed_out_d;
   logic               hang_q, hang_d;
   logic               core_rst_q, running_q, done_q;

   logic               cnt_clr;
   logic               run_en;
   logic               tohost_hit;
   verdict_e           verdict;
   logic [CNT_W-1:0]   cycle_cnt, retire_cnt;
   logic [STALL_W-1:0] stall_cnt;

   assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      pass_d      = pass_q;
      fail_code_d = fail_code_q;
      timed_out_d = timed_out_q;
      hang_d      = hang_q;
      cnt_clr     = 1'b0;
      run_en      = 1'b0;
      verdict     = V_NONE;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RST_HOLD;
               hold_d      = '0;
               cnt_clr     = 1'b1;
               pass_d      = 1'b0;
               fail_code_d = '0;
               timed_out_d = 1'b0;
               hang_d      = 1'b0;
            end
         end
         RST_HOLD: begin
            if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         RUN: begin
            run_en = 1'b1;
            // Priority: a tohost store outranks a timeout, which outranks a hang.
            if (tohost_hit) begin
               verdict = (mem_wdata == 32'd1) ? V_PASS : V_FAIL;
            end else if (cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
               verdict = V_TIMEOUT;
            end else if ((stall_cnt == STALL_W'(STALL_LIMIT - 1)) && !retire) begin
               verdict = V_HANG;
            end

            if (verdict != V_NONE) begin
               state_d     = DONE;
               pass_d      = (verdict == V_PASS);
               fail_code_d = tohost_hit ? mem_wdata[31:1] : 31'd0;
               timed_out_d = (verdict == V_TIMEOUT);
               hang_d      = (verdict == V_HANG);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         pass_q      <= 1'b0;
         fail_code_q <= '0;
         timed_out_q <= 1'b0;
         hang_q      <= 1'b0;
         core_rst_q  <= 1'b1;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         pass_q      <= pass_d;
         fail_code_q <= fail_code_d;
         timed_out_q <= timed_out_d;
         hang_q      <= hang_d;
         core_rst_q  <= (state_d != RUN);
         running_q   <= (state_d == RUN);
         done_q      <= (state_d == DONE);
      end
   end

   // Counters advance only in RUN, so they freeze once DONE is entered.
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (cnt_clr),
      .en_i   (run_en),
      .cnt_o  (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (cnt_clr),
      .en_i   (run_en && retire),
      .cnt_o  (retire_cnt)
   );

   sat_counter #(.W(STALL_W)) u_stall_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (cnt_clr || (run_en && retire)),
      .en_i   (run_en && !retire),
      .cnt_o  (stall_cnt)
   );

   assign core_rst     = core_rst_q;
   assign running      = running_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail_code    = fail_code_q;
   assign timed_out    = timed_out_q;
   assign hang         = hang_q;
   assign cycle_count  = cycle_cnt;
   assign retire_count = retire_cnt;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Self-checking bench for riscv_run_monitor: directed scenarios plus random
// runs, compared every cycle against a behavioural run model.
module tb_riscv_run_monitor;

   localparam logic [31:0] TOHOST = 32'h0000_0FF0;
   localparam int RSTC    = 4;
   localparam int TIMEOUT = 100;
   localparam int STALL   = 16;

   localparam int M_IDLE = 0;
   localparam int M_HOLD = 1;
   localparam int M_RUN  = 2;
   localparam int M_DONE = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        retire = 1'b0;
   logic        core_rst, running, done, pass, timed_out, hang;
   logic [30:0] fail_code;
   logic [31:0] cycle_count, retire_count;

   int n_checks = 0;
   int n_pass = 0;

   riscv_run_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .retire       (retire),
      .core_rst     (core_rst),
      .running      (running),
      .done         (done),
      .pass         (pass),
      .fail_code    (fail_code),
      .timed_out    (timed_out),
      .hang         (hang),
      .cycle_count  (cycle_count),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: a run phase, a reset countdown, and plain counts.
   int          m_mode = M_IDLE;
   int          m_hold_left = 0;
   logic [31:0] m_cyc = '0;
   logic [31:0] m_ret = '0;
   int          m_idle_run = 0;
   logic        m_pass = 1'b0;
   logic [30:0] m_fc = '0;
   logic        m_to = 1'b0;
   logic        m_hang = 1'b0;

   wire m_tohost  = mem_we && (mem_addr == TOHOST) && mem_wdata[0];
   wire m_timeout = (m_cyc == 32'(TIMEOUT - 1));
   wire m_stalled = (m_idle_run == STALL - 1) && !retire;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode <= M_IDLE; m_hold_left <= 0; m_cyc <= '0; m_ret <= '0; m_idle_run <= 0;
         m_pass <= 1'b0; m_fc <= '0; m_to <= 1'b0; m_hang <= 1'b0;
      end else if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
         m_mode <= M_HOLD; m_hold_left <= RSTC - 1; m_cyc <= '0; m_ret <= '0; m_idle_run <= 0;
         m_pass <= 1'b0; m_fc <= '0; m_to <= 1'b0; m_hang <= 1'b0;
      end else if (m_mode == M_HOLD) begin
         if (m_hold_left == 0) m_mode <= M_RUN;
         else m_hold_left <= m_hold_left - 1;
      end else if (m_mode == M_RUN) begin
         if (m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 1;
         if (retire && m_ret != 32'hFFFF_FFFF) m_ret <= m_ret + 1;
         m_idle_run <= retire ? 0 : m_idle_run + 1;
         if (m_tohost) begin
            m_mode <= M_DONE; m_pass <= (mem_wdata == 32'd1); m_fc <= mem_wdata[31:1];
         end else if (m_timeout) begin
            m_mode <= M_DONE; m_to <= 1'b1;
         end else if (m_stalled) begin
            m_mode <= M_DONE; m_hang <= 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         n_checks++;
         if (core_rst !== (m_mode != M_RUN) || running !== (m_mode == M_RUN) ||
             done !== (m_mode == M_DONE) || pass !== m_pass || fail_code !== m_fc ||
             timed_out !== m_to || hang !== m_hang || cycle_count !== m_cyc ||
             retire_count !== m_ret) begin
            $display("FAIL model_cmp t=%0t got rst=%0b run=%0b done=%0b pass=%0b fc=%0h to=%0b hang=%0b cyc=%0d ret=%0d | want rst=%0b run=%0b done=%0b pass=%0b fc=%0h to=%0b hang=%0b cyc=%0d ret=%0d",
                     $time, core_rst, running, done, pass, fail_code, timed_out, hang, cycle_count, retire_count,
                     m_mode != M_RUN, m_mode == M_RUN, m_mode == M_DONE, m_pass, m_fc, m_to, m_hang, m_cyc, m_ret);
         end else begin
            n_pass++;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_run();
      for (int i = 0; i < 20 && !running; i++) step();
      chk("run_entry", running, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && !done; i++) step();
      chk("done_reached", done, 1);
   endtask

   task automatic count_hold(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 20 && core_rst; i++) begin
         n++;
         step();
      end
      chk(name, n, RSTC);
      chk({name, "_running"}, running, 1);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
      step();
      mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
   endtask

   initial begin
      int rp;
      bit aborted;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_cycle_count", cycle_count, 0);
      reset = 1'b1;
      repeat (3) step();
      chk("idle_core_rst", core_rst, 1);
      chk("idle_running", running, 0);

      // Reset hold length, then pass on RUN cycle 20
      do_start();
      count_hold("hold_len");
      retire = 1'b1;
      repeat (20) step();
      store(TOHOST, 32'd1);
      chk("pass_done", done, 1);
      chk("pass_pass", pass, 1);
      chk("pass_fc", fail_code, 0);
      chk("pass_cyc", cycle_count, 21);
      chk("pass_ret", retire_count, 21);

      // Fail store on the same cycle the timeout would fire
      do_start();
      wait_run();
      repeat (99) step();
      store(TOHOST, 32'h0000_0007);
      chk("fail_done", done, 1);
      chk("fail_pass", pass, 0);
      chk("fail_fc", fail_code, 3);
      chk("fail_to", timed_out, 0);
      chk("fail_cyc", cycle_count, 100);

      // Timeout with steady retires
      do_start();
      wait_run();
      wait_done();
      chk("to_flag", timed_out, 1);
      chk("to_cyc", cycle_count, 100);
      chk("to_ret", retire_count, 100);
      chk("to_hang", hang, 0);

      // Hang with no retires from RUN entry
      retire = 1'b0;
      do_start();
      wait_run();
      wait_done();
      chk("hang_flag", hang, 1);
      chk("hang_cyc", cycle_count, 16);
      chk("hang_ret", retire_count, 0);
      chk("hang_to", timed_out, 0);

      // Abort mid-run
      retire = 1'b1;
      do_start();
      wait_run();
      repeat (10) step();
      reset = 1'b0;
      #1;
      chk("abort_core_rst", core_rst, 1);
      chk("abort_running", running, 0);
      chk("abort_cyc", cycle_count, 0);
      chk("abort_ret", retire_count, 0);
      repeat (2) step();
      reset = 1'b1;

      // Reach DONE via hang, then restart from DONE
      retire = 1'b0;
      do_start();
      wait_run();
      wait_done();
      do_start();
      chk("restart_cyc", cycle_count, 0);
      chk("restart_hang", hang, 0);
      chk("restart_done", done, 0);
      count_hold("restart_hold");
      retire = 1'b1;
      repeat (5) step();
      store(TOHOST, 32'd1);
      chk("restart_pass", pass, 1);
      chk("restart_cyc_end", cycle_count, 6);

      // Random runs: stores to assorted addresses/values, stray starts, aborts
      for (int r = 0; r < 40; r++) begin
         rp = $urandom_range(0, 3);
         aborted = 1'b0;
         do_start();
         wait_run();
         for (int c = 0; c < 150 && !done && !aborted; c++) begin
            retire = (rp == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            mem_we = ($urandom_range(0, 29) == 0);
            mem_addr = ($urandom_range(0, 1) == 0) ? TOHOST : $urandom;
            case ($urandom_range(0, 2))
               0: mem_wdata = 32'd1;
               1: mem_wdata = $urandom;
               default: mem_wdata = $urandom & 32'hFFFF_FFFE;
            endcase
            start = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) begin
               reset = 1'b0;
               aborted = 1'b1;
            end
            step();
            reset = 1'b1;
         end
         start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
         if (!aborted) chk("rand_done", done, 1);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
